timer_tick_sequencer: RTL and testbench
=======================================

Name: timer_tick_sequencer

Overview:
- Avalon-MM master that programs and services the system interval timer (16-bit, 3-bit word address, registered readdata, no waitrequest).
- Loads the period, starts the timer in continuous mode with IRQ enabled, and clears each timeout.
- Emits one tick pulse per timeout and keeps a wrapping tick counter.
- Sits between the control logic (start/stop/period) and the timer slave port, replacing software servicing of the timer.

Parameters:
- CNT_W, 16, width of tick_count.
- DEF_PERIOD, 32'd49999, period loaded when start_i arrives with period_i == 0.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_i  in  1  pulse: (re)program period and start
- stop_i  in  1  pulse: stop timer
- period_i  in  32  timer load value; timeout every period_i+1 clocks
- tmr_irq  in  1  timer interrupt
- tmr_readdata  in  16  timer read data, valid 1 clk after address
- tmr_address  out  3  timer word address
- tmr_chipselect  out  1  timer select
- tmr_write_n  out  1  active-low write
- tmr_writedata  out  16  timer write data
- tick_o  out  1  one-clock pulse per serviced timeout
- tick_count  out  CNT_W  serviced timeouts, wraps to 0
- running_o  out  1  high in RUN
- busy_o  out  1  high in any state other than IDLE or RUN

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values:
  - state=IDLE.
  - tmr_chipselect=0, tmr_write_n=1, tmr_address=0, tmr_writedata=0.
  - tick_o=0, tick_count=0, running_o=0, busy_o=0.
  - Pending flags cleared.
- All outputs are registered. Each timer access is a single-cycle write: chipselect=1 and write_n=0 for exactly one clock.
- States and the write each one issues:
  - IDLE: no access.
  - WR_PL: addr 2, data = period[15:0].
  - WR_PH: addr 3, data = period[31:16].
  - WR_CTRL_GO: addr 1, data 0x0007 (ITO, CONT, START).
  - RUN: no access.
  - WR_CLR: addr 0, data 0x0000.
  - WR_CTRL_STOP: addr 1, data 0x0008.
  - WR_CLR_STOP: addr 0, data 0x0000.
- Transitions:
  - IDLE --start--> WR_PL. The period is latched at the start_i cycle; period_i==0 selects DEF_PERIOD.
  - WR_PL -> WR_PH -> WR_CTRL_GO -> RUN, one clock each. The first write reaches the bus 1 clk after start_i; running_o rises 4 clks after start_i.
  - RUN --tmr_irq--> WR_CLR. In the WR_CLR cycle, tick_o=1 and tick_count increments. WR_CLR then returns to RUN. tmr_irq is ignored in WR_CLR and during the following RUN cycle (irq deasserts one clk after the clear write).
  - RUN --stop--> WR_CTRL_STOP -> WR_CLR_STOP -> IDLE.
  - RUN --start--> WR_PL. This reprograms the period; the period writes force a reload and stop the timer, and WR_CTRL_GO restarts it.
  - IDLE --stop--> ignored.
- Priority in RUN when events coincide: stop > start > irq. A coincident irq is discarded and gives no tick; the status is still cleared in WR_CLR_STOP.
- start_i/stop_i in busy states:
  - Latched into pend_start/pend_stop. A stop clears pend_start; a later start clears pend_stop.
  - Serviced in the first IDLE/RUN cycle with the same priority.
  - pend_start re-samples period_i at the cycle it was latched.
- tick_count wraps from 2^CNT_W-1 to 0. It is held when stopped and cleared only by reset.
- Reset mid-sequence returns to IDLE immediately. The timer keeps whatever was already written.

Optional Feature:
- Macro: TIMER_TICK_SEQUENCER_SNAPSHOT_EN.
- With it defined, the block adds ports snap_req_i (in 1), snap_o (out 32) and snap_valid_o (out 1). Each reads as 0 at reset.
  - snap_req_i in RUN (lowest priority, else pended) enters SNAP_WR: write addr 4, any data.
  - SNAP_RD_L drives addr 4, read. SNAP_RD_H drives addr 5 and captures tmr_readdata into snap_o[15:0].
  - SNAP_CAP captures snap_o[31:16], pulses snap_valid_o for 1 clk, then returns to RUN.
  - An irq arriving during a snapshot is serviced next; the IRQ level holds until cleared.
- Without it, none of these ports or states exist.

Decomposition:
- Shared package timer_seq_pkg:
  - State enum.
  - Timer register addresses: STATUS=0, CONTROL=1, PERIODL=2, PERIODH=3, SNAPL=4, SNAPH=5.
  - Control constants: CTRL_GO=16'h0007, CTRL_STOP=16'h0008.
- No sub-module. A single FSM with a registered bus-output stage.

Test Plan:
- Reset, start_i with period_i=9 -> writes (2,0x0009), (3,0x0000), (1,0x0007) on consecutive clocks. running_o rises 4 clks after start_i.
- Bench timer model period 9, run 100 clks -> tick_o every 10 clks, each tick followed by write (0,0x0000), tick_count=number of ticks.
- stop_i and tmr_irq in the same RUN cycle -> writes (1,0x0008) then (0,0x0000), no tick, IDLE, tick_count unchanged.
- start_i during WR_PH, new period 0 -> sequence finishes, RUN one clk, then reprograms with (2,0xC34F),(3,0x0000).
- CNT_W=4, 17 timeouts -> tick_count=1. Reset asserted in WR_PH -> all outputs at reset values, no further writes.
- Snapshot build: model counter snapshot 0x0001_2345 -> write addr 4, reads 4/5, snap_o=0x00012345, snap_valid_o 1-clk pulse.

Source files
------------

// File: rtl/timer_tick_sequencer_pkg.sv
// rtl/timer_tick_sequencer_pkg.sv - shared states, timer register map and control words
// TIMER_TICK_SEQUENCER_SNAPSHOT_EN adds the snapshot states to the enum.
package timer_seq_pkg;

`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL_GO, RUN, WR_CLR, WR_CTRL_STOP, WR_CLR_STOP,
        SNAP_WR, SNAP_RD_L, SNAP_RD_H, SNAP_CAP
    } state_e;
`else
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL_GO, RUN, WR_CLR, WR_CTRL_STOP, WR_CLR_STOP
    } state_e;
`endif

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERIODL = 3'd2;
    localparam logic [2:0] ADDR_PERIODH = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam logic [15:0] CTRL_GO   = 16'h0007;
    localparam logic [15:0] CTRL_STOP = 16'h0008;

    function automatic logic [31:0] sel_period(input logic [31:0] p, input logic [31:0] def);
        return (p == 32'd0) ? def : p;
    endfunction

endpackage

// File: rtl/timer_tick_sequencer_if.sv
// rtl/timer_tick_sequencer_if.sv - Avalon-MM timer slave port bundle plus its interrupt line
interface timer_tick_sequencer_if;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect;
    logic        tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] tmr_readdata;
    logic        tmr_irq;

    modport master (
        output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        input  tmr_readdata, tmr_irq
    );
    modport slave (
        input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
        output tmr_readdata, tmr_irq
    );
endinterface

// File: rtl/timer_tick_sequencer.sv
// rtl/timer_tick_sequencer.sv - programs the interval timer, clears each timeout, counts ticks
// Optional counter snapshot readout: TIMER_TICK_SEQUENCER_SNAPSHOT_EN.
module timer_tick_sequencer
    import timer_seq_pkg::*;
#(
    parameter int          CNT_W      = 16,
    parameter logic [31:0] DEF_PERIOD = 32'd49999
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start_i,
    input  logic                 stop_i,
    input  logic [31:0]          period_i,
    timer_tick_sequencer_if.master tmr,
    output logic                 tick_o,
    output logic [CNT_W-1:0]     tick_count,
    output logic                 running_o,
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
    input  logic                 snap_req_i,
    output logic [31:0]          snap_o,
    output logic                 snap_valid_o,
`endif
    output logic                 busy_o
);

    state_e            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic [31:0]       pend_period_q, pend_period_d;
    logic              pend_start_q, pend_start_d;
    logic              pend_stop_q, pend_stop_d;
    logic              clr_hold_q, clr_hold_d;
    logic [2:0]        addr_q, addr_d;
    logic              cs_q, cs_d;
    logic              wn_q, wn_d;
    logic [15:0]       wd_q, wd_d;
    logic              tick_q, tick_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              run_q, run_d;
    logic              busy_q, busy_d;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
    logic              pend_snap_q, pend_snap_d;
    logic [31:0]       snap_q, snap_d;
    logic              snap_valid_q, snap_valid_d;
`else
    logic              unused_rd;
    assign unused_rd = ^tmr.tmr_readdata;
`endif

    logic        go_start, go_stop, serviceable;
    logic [31:0] start_period;

    always_comb begin
        state_d       = state_q;
        period_d      = period_q;
        pend_period_d = pend_period_q;
        pend_start_d  = pend_start_q;
        pend_stop_d   = pend_stop_q;
        // The irq level stays high for one more cycle after the clear write.
        clr_hold_d    = (state_q == WR_CLR);
        serviceable   = (state_q == IDLE) || (state_q == RUN);
        go_start      = start_i | pend_start_q;
        go_stop       = stop_i | pend_stop_q;
        start_period  = start_i ? period_i : pend_period_q;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
        pend_snap_d   = pend_snap_q;
        snap_d        = snap_q;
        snap_valid_d  = (state_q == SNAP_CAP);
        if (!serviceable && snap_req_i) pend_snap_d = 1'b1;
`endif
        if (!serviceable) begin
            if (stop_i) begin
                pend_stop_d  = 1'b1;
                pend_start_d = 1'b0;
            end else if (start_i) begin
                pend_start_d  = 1'b1;
                pend_stop_d   = 1'b0;
                pend_period_d = period_i;
            end
        end

        case (state_q)
            IDLE: begin
                pend_start_d = 1'b0;
                pend_stop_d  = 1'b0;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
                pend_snap_d  = 1'b0;
`endif
                if (go_start) begin
                    state_d  = WR_PL;
                    period_d = sel_period(start_period, DEF_PERIOD);
                end
            end
            WR_PL:        state_d = WR_PH;
            WR_PH:        state_d = WR_CTRL_GO;
            WR_CTRL_GO:   state_d = RUN;
            RUN: begin
                pend_start_d = 1'b0;
                pend_stop_d  = 1'b0;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
                pend_snap_d  = pend_snap_q | snap_req_i;
`endif
                if (go_stop) begin
                    state_d = WR_CTRL_STOP;
                end else if (go_start) begin
                    state_d  = WR_PL;
                    period_d = sel_period(start_period, DEF_PERIOD);
                end else if (tmr.tmr_irq && !clr_hold_q) begin
                    state_d = WR_CLR;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
                end else if (snap_req_i || pend_snap_q) begin
                    state_d     = SNAP_WR;
                    pend_snap_d = 1'b0;
`endif
                end
            end
            WR_CLR:       state_d = RUN;
            WR_CTRL_STOP: state_d = WR_CLR_STOP;
            WR_CLR_STOP:  state_d = IDLE;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
            SNAP_WR:      state_d = SNAP_RD_L;
            SNAP_RD_L:    state_d = SNAP_RD_H;
            SNAP_RD_H: begin
                state_d       = SNAP_CAP;
                snap_d[15:0]  = tmr.tmr_readdata;
            end
            SNAP_CAP: begin
                state_d       = RUN;
                snap_d[31:16] = tmr.tmr_readdata;
            end
`endif
            default:      state_d = IDLE;
        endcase

        // Bus and status outputs are decoded from the next state so they register with it.
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = ADDR_STATUS;
        wd_d   = 16'h0000;
        case (state_d)
            WR_PL:        begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIODL; wd_d = period_d[15:0];  end
            WR_PH:        begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_PERIODH; wd_d = period_d[31:16]; end
            WR_CTRL_GO:   begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL; wd_d = CTRL_GO;         end
            WR_CLR:       begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;                          end
            WR_CTRL_STOP: begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_CONTROL; wd_d = CTRL_STOP;       end
            WR_CLR_STOP:  begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_STATUS;                          end
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
            SNAP_WR:      begin cs_d = 1'b1; wn_d = 1'b0; addr_d = ADDR_SNAPL;                           end
            SNAP_RD_L:    begin cs_d = 1'b1;              addr_d = ADDR_SNAPL;                           end
            SNAP_RD_H:    begin cs_d = 1'b1;              addr_d = ADDR_SNAPH;                           end
`endif
            default:      ;
        endcase
        tick_d = (state_d == WR_CLR);
        cnt_d  = cnt_q + CNT_W'(tick_d);
        run_d  = (state_d == RUN);
        busy_d = (state_d != IDLE) && (state_d != RUN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            period_q      <= 32'd0;
            pend_period_q <= 32'd0;
            pend_start_q  <= 1'b0;
            pend_stop_q   <= 1'b0;
            clr_hold_q    <= 1'b0;
            addr_q        <= 3'd0;
            cs_q          <= 1'b0;
            wn_q          <= 1'b1;
            wd_q          <= 16'h0000;
            tick_q        <= 1'b0;
            cnt_q         <= '0;
            run_q         <= 1'b0;
            busy_q        <= 1'b0;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
            pend_snap_q   <= 1'b0;
            snap_q        <= 32'd0;
            snap_valid_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            period_q      <= period_d;
            pend_period_q <= pend_period_d;
            pend_start_q  <= pend_start_d;
            pend_stop_q   <= pend_stop_d;
            clr_hold_q    <= clr_hold_d;
            addr_q        <= addr_d;
            cs_q          <= cs_d;
            wn_q          <= wn_d;
            wd_q          <= wd_d;
            tick_q        <= tick_d;
            cnt_q         <= cnt_d;
            run_q         <= run_d;
            busy_q        <= busy_d;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
            pend_snap_q   <= pend_snap_d;
            snap_q        <= snap_d;
            snap_valid_q  <= snap_valid_d;
`endif
        end
    end

    assign tmr.tmr_address    = addr_q;
    assign tmr.tmr_chipselect = cs_q;
    assign tmr.tmr_write_n    = wn_q;
    assign tmr.tmr_writedata  = wd_q;
    assign tick_o             = tick_q;
    assign tick_count         = cnt_q;
    assign running_o          = run_q;
    assign busy_o             = busy_q;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
    assign snap_o             = snap_q;
    assign snap_valid_o       = snap_valid_q;
`endif

endmodule

// File: tb/tb_timer_tick_sequencer.sv
// tb/tb_timer_tick_sequencer.sv - directed bench with a behavioural interval timer model
module tb_timer_tick_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [31:0] period_i = 32'd0;
    logic        tick_o, running_o, busy_o;
    logic [15:0] tick_count;
    logic        tick4, running4, busy4;
    logic [3:0]  tick_count4;
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
    logic        snap_req_i = 1'b0;
    logic [31:0] snap_o, snap4;
    logic        snap_valid_o, snap_valid4;
`endif

    int checks = 0;
    int failures = 0;
    int nticks = 0;
    int last_tick = -1;
    logic any_cs;

    timer_tick_sequencer_if tmr ();
    timer_tick_sequencer_if tmr4 ();

    timer_tick_sequencer #(.CNT_W(16), .DEF_PERIOD(32'd49999)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
        .period_i(period_i), .tmr(tmr.master), .tick_o(tick_o),
        .tick_count(tick_count), .running_o(running_o),
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
        .snap_req_i(snap_req_i), .snap_o(snap_o), .snap_valid_o(snap_valid_o),
`endif
        .busy_o(busy_o)
    );

    timer_tick_sequencer #(.CNT_W(4), .DEF_PERIOD(32'd49999)) dut4 (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .stop_i(stop_i),
        .period_i(period_i), .tmr(tmr4.master), .tick_o(tick4),
        .tick_count(tick_count4), .running_o(running4),
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
        .snap_req_i(snap_req_i), .snap_o(snap4), .snap_valid_o(snap_valid4),
`endif
        .busy_o(busy4)
    );

    always #5 clk = ~clk;

    // Behavioural interval timer: counts period..0, sets TO on wrap, keeps state across DUT reset.
    logic [31:0] m_period = 32'd0;
    logic [31:0] m_cnt = 32'd0;
    logic        m_run = 1'b0;
    logic        m_to = 1'b0;
    logic [15:0] m_rd = 16'h0;

    always @(posedge clk) begin
        if (m_run) begin
            if (m_cnt == 32'd0) begin
                m_to  <= 1'b1;
                m_cnt <= m_period;
            end else begin
                m_cnt <= m_cnt - 32'd1;
            end
        end
        if (tmr.tmr_chipselect) begin
            m_rd <= (tmr.tmr_address == 3'd4) ? 16'h2345 :
                    (tmr.tmr_address == 3'd5) ? 16'h0001 : 16'h0000;
        end
        if (tmr.tmr_chipselect && !tmr.tmr_write_n) begin
            case (tmr.tmr_address)
                3'd0: m_to <= 1'b0;
                3'd1: begin
                    if (tmr.tmr_writedata[2]) begin
                        m_run <= 1'b1;
                        m_cnt <= m_period;
                    end else if (tmr.tmr_writedata[3]) begin
                        m_run <= 1'b0;
                    end
                end
                3'd2: begin m_period[15:0]  <= tmr.tmr_writedata; m_run <= 1'b0; end
                3'd3: begin m_period[31:16] <= tmr.tmr_writedata; m_run <= 1'b0; end
                default: ;
            endcase
        end
    end

    assign tmr.tmr_irq       = m_to;
    assign tmr.tmr_readdata  = m_rd;
    assign tmr4.tmr_irq      = m_to;
    assign tmr4.tmr_readdata = m_rd;

    logic [20:0] bus;
    assign bus = {tmr.tmr_chipselect, tmr.tmr_write_n, tmr.tmr_address, tmr.tmr_writedata};

    localparam logic [20:0] BUS_IDLE = {2'b01, 3'd0, 16'h0000};

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {2'b10, a, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic watch_ticks(input int first, input int limit, input int stop_at);
        for (int i = first; i < limit && nticks < stop_at; i++) begin
            @(negedge clk);
            if (tick_o) begin
                check("tick_clr_wr", 32'(bus), 32'(wr(3'd0, 16'h0000)));
                if (last_tick >= 0) check("tick_gap", i - last_tick, 10);
                last_tick = i;
                nticks++;
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_bus", 32'(bus), 32'(BUS_IDLE));
        check("rst_flags", {tick_o, running_o, busy_o}, 3'b000);
        check("rst_count", tick_count, 0);
`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
        check("rst_snap", {snap_valid_o, snap_o}, 33'd0);
`endif
        reset_n = 1'b1;
        @(negedge clk);

        // Program period 9 from IDLE
        start_i = 1'b1; period_i = 32'd9;
        @(negedge clk); start_i = 1'b0;
        check("go_pl", 32'(bus), 32'(wr(3'd2, 16'h0009)));
        check("go_busy", busy_o, 1);
        @(negedge clk);
        check("go_ph", 32'(bus), 32'(wr(3'd3, 16'h0000)));
        @(negedge clk);
        check("go_ctrl", 32'(bus), 32'(wr(3'd1, 16'h0007)));
        check("go_run_early", running_o, 0);
        @(negedge clk);
        check("go_run", {running_o, busy_o}, 2'b10);
        check("go_bus_idle", 32'(bus), 32'(BUS_IDLE));

        // 100 clocks of servicing: first tick 11 clocks after the control write
        watch_ticks(0, 100, 1000);
        check("ticks_100", nticks, 9);
        check("count_100", tick_count, nticks);
        watch_ticks(100, 400, 17);
        check("ticks_17", nticks, 17);
        check("count_17", tick_count, 17);
        check("count4_wrap", tick_count4, 1);

        // stop and irq in the same RUN cycle
        begin
            int waited = 0;
            while (!(tmr.tmr_irq && running_o) && waited < 30) begin
                @(negedge clk); waited++;
            end
            check("irq_wait", (waited < 30), 1);
        end
        stop_i = 1'b1;
        @(negedge clk); stop_i = 1'b0;
        check("stop_ctrl", 32'(bus), 32'(wr(3'd1, 16'h0008)));
        check("stop_notick", tick_o, 0);
        @(negedge clk);
        check("stop_clr", 32'(bus), 32'(wr(3'd0, 16'h0000)));
        check("stop_notick2", tick_o, 0);
        @(negedge clk);
        check("stop_idle", {running_o, busy_o}, 2'b00);
        check("stop_count", tick_count, 17);
        check("stop_irq_cleared", tmr.tmr_irq, 0);

        // start during WR_PH with period 0 pends a default-period reprogram
        start_i = 1'b1; period_i = 32'd9;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        check("pend_ph", 32'(bus), 32'(wr(3'd3, 16'h0000)));
        start_i = 1'b1; period_i = 32'd0;
        @(negedge clk); start_i = 1'b0;
        check("pend_ctrl", 32'(bus), 32'(wr(3'd1, 16'h0007)));
        @(negedge clk);
        check("pend_run1", {running_o, 32'(bus)}, {1'b1, 32'(BUS_IDLE)});
        @(negedge clk);
        check("pend_pl", 32'(bus), 32'(wr(3'd2, 16'hC34F)));
        check("pend_notrun", running_o, 0);
        @(negedge clk);
        check("pend_ph2", 32'(bus), 32'(wr(3'd3, 16'h0000)));
        @(negedge clk);
        check("pend_ctrl2", 32'(bus), 32'(wr(3'd1, 16'h0007)));
        @(negedge clk);
        check("pend_run2", running_o, 1);

        // reset asserted in WR_PH
        start_i = 1'b1; period_i = 32'd9;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk);
        check("rst_mid_ph", 32'(bus), 32'(wr(3'd3, 16'h0000)));
        reset_n = 1'b0;
        #1;
        check("rst_mid_bus", 32'(bus), 32'(BUS_IDLE));
        check("rst_mid_flags", {tick_o, running_o, busy_o}, 3'b000);
        check("rst_mid_count", {tick_count4, tick_count}, 20'd0);
        @(negedge clk);
        reset_n = 1'b1;
        any_cs = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            any_cs = any_cs | tmr.tmr_chipselect | busy_o | running_o;
        end
        check("rst_quiet", any_cs, 0);

`ifdef TIMER_TICK_SEQUENCER_SNAPSHOT_EN
        start_i = 1'b1; period_i = 32'd9;
        @(negedge clk); start_i = 1'b0;
        repeat (4) @(negedge clk);
        snap_req_i = 1'b1;
        @(negedge clk); snap_req_i = 1'b0;
        check("snap_wr", {bus[20:16]}, {2'b10, 3'd4});
        @(negedge clk);
        check("snap_rd_l", {bus[20:16]}, {2'b11, 3'd4});
        @(negedge clk);
        check("snap_rd_h", {bus[20:16]}, {2'b11, 3'd5});
        @(negedge clk);
        check("snap_cap_novalid", snap_valid_o, 0);
        @(negedge clk);
        check("snap_valid", snap_valid_o, 1);
        check("snap_data", snap_o, 32'h0001_2345);
        check("snap_run", running_o, 1);
        @(negedge clk);
        check("snap_pulse_end", snap_valid_o, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
